// File: rtl/dahb_master.sv
`timescale 1ns/1ps
// Data-side AHB-Lite master: buffers single load/store requests from the MEM-stage
// controller and issues them as pipelined AHB-Lite single transfers.
module dahb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  DAHB_access,
  input  logic                  DAHB_rd0_wr1,
  input  logic [2:0]            DAHB_size,
  input  logic [DATA_WIDTH-1:0] DAHB_write_data,
  input  logic [ADDR_WIDTH-1:0] DAHB_addr,
  output logic                  DAHB_trans_buffer_full,
  output logic [DATA_WIDTH-1:0] DAHB_read_data,
  output logic                  DAHB_read_data_valid,
  output logic                  dahb_bus_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic                  write;
    logic [2:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic {DP_IDLE, DP_BUSY} dp_state_t;

  req_t             buf_q [BUF_DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  dp_state_t        dp_state_q, dp_state_d;
  logic             dp_write_q;
  logic [DATA_WIDTH-1:0] dp_wdata_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic             rd_valid_q, bus_err_q;

  logic push, pop, dp_busy, dp_done, err_first, non_empty;

  assign head      = buf_q[rd_ptr_q];
  assign non_empty = (count_q != '0);
  assign dp_busy   = (dp_state_q == DP_BUSY);
  // First ERROR cycle cancels the pending address phase; the head stays queued.
  assign err_first = dp_busy && HRESP && !HREADY;
  assign push      = DAHB_access && !full_q;
  assign pop       = non_empty && !err_first && HREADY;
  assign dp_done   = dp_busy && HREADY;

  assign HTRANS = (non_empty && !err_first) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = head.addr;
  assign HWRITE = head.write;
  assign HSIZE  = head.size;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;
  assign HWDATA = dp_wdata_q;

  assign DAHB_trans_buffer_full = full_q;
  assign DAHB_read_data         = rd_data_q;
  assign DAHB_read_data_valid   = rd_valid_q;
  assign dahb_bus_err           = bus_err_q;

  // Occupancy next-state; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!push && pop)
      count_d = count_q - CNT_W'(1);
  end

  // Data-phase tracker next-state.
  always_comb begin
    dp_state_d = dp_state_q;
    if (pop)
      dp_state_d = DP_BUSY;
    else if (dp_done)
      dp_state_d = DP_IDLE;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)
      dp_state_q <= DP_IDLE;
    else
      dp_state_q <= dp_state_d;
  end

  // Transfer buffer storage and pointers.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++)
        buf_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= '{write: DAHB_rd0_wr1, size: DAHB_size,
                             addr: DAHB_addr, wdata: DAHB_write_data};
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(BUF_DEPTH));
    end
  end

  // Data-phase payload and completion reporting.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      dp_write_q <= 1'b0;
      dp_wdata_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if (pop) begin
        dp_write_q <= head.write;
        dp_wdata_q <= head.wdata;
      end
      rd_valid_q <= dp_done && !dp_write_q;
      bus_err_q  <= dp_done && HRESP;
      if (dp_done && !dp_write_q)
        rd_data_q <= HRESP ? '0 : HRDATA;
    end
  end

endmodule

// File: tb/tb_dahb_master.sv
`timescale 1ns/1ps
// Directed self-checking bench for dahb_master: single-transfer vector table plus
// hand-written sequences for wait states, back-pressure, ERROR and mid-run reset.
module tb_dahb_master;

  logic        cpu_clk, cpu_rstn;
  logic        DAHB_access, DAHB_rd0_wr1;
  logic [2:0]  DAHB_size;
  logic [31:0] DAHB_write_data, DAHB_addr;
  logic        DAHB_trans_buffer_full;
  logic [31:0] DAHB_read_data;
  logic        DAHB_read_data_valid, dahb_bus_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY, HRESP;
  logic [31:0] HRDATA;

  int n_pass = 0;
  int n_total = 0;

  dahb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BUF_DEPTH(2)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .DAHB_access(DAHB_access), .DAHB_rd0_wr1(DAHB_rd0_wr1), .DAHB_size(DAHB_size),
    .DAHB_write_data(DAHB_write_data), .DAHB_addr(DAHB_addr),
    .DAHB_trans_buffer_full(DAHB_trans_buffer_full), .DAHB_read_data(DAHB_read_data),
    .DAHB_read_data_valid(DAHB_read_data_valid), .dahb_bus_err(dahb_bus_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd);
    DAHB_access = 1'b1; DAHB_rd0_wr1 = wr; DAHB_size = sz;
    DAHB_addr = a; DAHB_write_data = wd;
  endtask

  task automatic noreq();
    DAHB_access = 1'b0; DAHB_rd0_wr1 = 1'b0; DAHB_size = 3'b000;
    DAHB_addr = '0; DAHB_write_data = '0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic [31:0] exp_hwdata;
    logic        exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{1'b0, 3'b010, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 3'b001, 32'h2000_0022, 32'h5A5A_0000, 32'h1111_1111, 32'h5A5A_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 3'b000, 32'h0000_0003, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678};
    vecs[3] = '{1'b1, 3'b010, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h1234_5678};

    cpu_rstn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    noreq();
    #1;
    chk("rst_htrans", 64'(HTRANS), 64'h0);
    chk("rst_haddr", 64'(HADDR), 64'h0);
    chk("rst_full", 64'(DAHB_trans_buffer_full), 64'h0);
    chk("rst_valid", 64'(DAHB_read_data_valid), 64'h0);
    chk("rst_hburst", 64'(HBURST), 64'h0);
    chk("rst_hprot", 64'(HPROT), 64'h3);
    #20 cpu_rstn = 1'b1;
    tick();

    // Single transfers, zero-wait slave.
    for (int i = 0; i < 4; i++) begin
      req(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      #1 chk("v_idle_before", 64'(HTRANS), 64'h0);
      tick(); noreq();
      #1;
      chk("v_nonseq", 64'(HTRANS), 64'h2);
      chk("v_haddr", 64'(HADDR), 64'(vecs[i].addr));
      chk("v_hsize", 64'(HSIZE), 64'(vecs[i].size));
      chk("v_hwrite", 64'(HWRITE), 64'(vecs[i].wr));
      tick(); HRDATA = vecs[i].hrdata;
      #1;
      chk("v_dp_idle", 64'(HTRANS), 64'h0);
      if (vecs[i].wr) chk("v_hwdata", 64'(HWDATA), 64'(vecs[i].exp_hwdata));
      chk("v_valid_early", 64'(DAHB_read_data_valid), 64'h0);
      tick(); HRDATA = '0;
      #1;
      chk("v_valid", 64'(DAHB_read_data_valid), 64'(vecs[i].exp_valid));
      chk("v_rdata", 64'(DAHB_read_data), 64'(vecs[i].exp_rdata));
      chk("v_err", 64'(dahb_bus_err), 64'h0);
      tick();
      #1 chk("v_valid_off", 64'(DAHB_read_data_valid), 64'h0);
    end

    // Three byte writes under 4 wait states: back-pressure and ordering.
    req(1'b1, 3'b000, 32'h100, 32'h11);
    tick(); HREADY = 1'b0;
    req(1'b1, 3'b000, 32'h101, 32'h2200);
    #1 chk("bp_full_c1", 64'(DAHB_trans_buffer_full), 64'h0);
    chk("bp_haddr_c1", 64'(HADDR), 64'h100);
    tick();
    req(1'b1, 3'b000, 32'h102, 32'h33_0000);
    #1 chk("bp_full_c2", 64'(DAHB_trans_buffer_full), 64'h1);
    tick();
    #1 chk("bp_haddr_c3", 64'(HADDR), 64'h100);
    chk("bp_htrans_c3", 64'(HTRANS), 64'h2);
    tick();
    #1 chk("bp_full_c4", 64'(DAHB_trans_buffer_full), 64'h1);
    tick(); HREADY = 1'b1;
    #1 chk("bp_full_c5", 64'(DAHB_trans_buffer_full), 64'h1);
    chk("bp_haddr_c5", 64'(HADDR), 64'h100);
    tick();
    #1 chk("bp_full_c6", 64'(DAHB_trans_buffer_full), 64'h0);
    chk("bp_hwdata_c6", 64'(HWDATA), 64'h11);
    chk("bp_haddr_c6", 64'(HADDR), 64'h101);
    tick(); noreq();
    #1 chk("bp_hwdata_c7", 64'(HWDATA), 64'h2200);
    chk("bp_haddr_c7", 64'(HADDR), 64'h102);
    chk("bp_valid_c7", 64'(DAHB_read_data_valid), 64'h0);
    tick();
    #1 chk("bp_hwdata_c8", 64'(HWDATA), 64'h33_0000);
    chk("bp_idle_c8", 64'(HTRANS), 64'h0);
    tick();
    #1 chk("bp_valid_c9", 64'(DAHB_read_data_valid), 64'h0);

    // Write with two wait states, followed by a read.
    req(1'b1, 3'b010, 32'h40, 32'hA5A5_A5A5);
    tick();
    req(1'b0, 3'b010, 32'h44, 32'h0);
    tick(); noreq(); HREADY = 1'b0;
    #1 chk("ww_hwdata", 64'(HWDATA), 64'hA5A5_A5A5);
    chk("ww_haddr_w1", 64'(HADDR), 64'h44);
    chk("ww_hwrite_w1", 64'(HWRITE), 64'h0);
    tick();
    #1 chk("ww_haddr_w2", 64'(HADDR), 64'h44);
    chk("ww_htrans_w2", 64'(HTRANS), 64'h2);
    tick(); HREADY = 1'b1;
    #1 chk("ww_haddr_rdy", 64'(HADDR), 64'h44);
    tick(); HRDATA = 32'h0BAD_CAFE;
    #1 chk("ww_idle", 64'(HTRANS), 64'h0);
    chk("ww_valid_early", 64'(DAHB_read_data_valid), 64'h0);
    tick(); HRDATA = '0;
    #1 chk("ww_valid", 64'(DAHB_read_data_valid), 64'h1);
    chk("ww_rdata", 64'(DAHB_read_data), 64'h0BAD_CAFE);
    tick();

    // Read hit by ERROR; queued write reissued afterwards.
    req(1'b0, 3'b010, 32'h80, 32'h0);
    tick();
    req(1'b1, 3'b010, 32'h84, 32'h77);
    tick(); noreq(); HRESP = 1'b1; HREADY = 1'b0; HRDATA = 32'hFFFF_FFFF;
    #1 chk("er_idle_first", 64'(HTRANS), 64'h0);
    chk("er_err_early", 64'(dahb_bus_err), 64'h0);
    tick(); HREADY = 1'b1;
    #1 chk("er_reissue", 64'(HTRANS), 64'h2);
    chk("er_haddr", 64'(HADDR), 64'h84);
    chk("er_hwrite", 64'(HWRITE), 64'h1);
    tick(); HRESP = 1'b0; HRDATA = '0;
    #1 chk("er_err", 64'(dahb_bus_err), 64'h1);
    chk("er_valid", 64'(DAHB_read_data_valid), 64'h1);
    chk("er_rdata", 64'(DAHB_read_data), 64'h0);
    chk("er_hwdata", 64'(HWDATA), 64'h77);
    tick();
    #1 chk("er_err_off", 64'(dahb_bus_err), 64'h0);
    chk("er_valid_off", 64'(DAHB_read_data_valid), 64'h0);
    chk("er_idle_after", 64'(HTRANS), 64'h0);

    // Reset during a read data phase with two entries queued.
    req(1'b0, 3'b010, 32'h200, 32'h99);
    tick();
    req(1'b1, 3'b010, 32'h204, 32'h5);
    tick(); HREADY = 1'b0;
    req(1'b1, 3'b010, 32'h208, 32'h6);
    tick(); noreq();
    #1 chk("rm_full_pre", 64'(DAHB_trans_buffer_full), 64'h1);
    chk("rm_hwdata_pre", 64'(HWDATA), 64'h99);
    cpu_rstn = 1'b0;
    #1;
    chk("rm_htrans", 64'(HTRANS), 64'h0);
    chk("rm_haddr", 64'(HADDR), 64'h0);
    chk("rm_hwrite", 64'(HWRITE), 64'h0);
    chk("rm_hsize", 64'(HSIZE), 64'h0);
    chk("rm_hwdata", 64'(HWDATA), 64'h0);
    chk("rm_full", 64'(DAHB_trans_buffer_full), 64'h0);
    chk("rm_rdata", 64'(DAHB_read_data), 64'h0);
    HREADY = 1'b1;
    #2 cpu_rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rm_post_idle", 64'(HTRANS), 64'h0);
      chk("rm_post_full", 64'(DAHB_trans_buffer_full), 64'h0);
      chk("rm_post_valid", 64'(DAHB_read_data_valid), 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
